// File: rtl/uproc_pkg.sv
// Shared definitions for the uProcessor core: instruction fields, opcodes,
// register codes and the fetch-sequencer state encoding.
package uproc_pkg;

    localparam int PMEM_ADDR_W = 5;
    localparam int OPC_FIELD_W = 4;
    localparam int REG_FIELD_W = 2;
    localparam int INS_WORD_W  = OPC_FIELD_W + REG_FIELD_W;

    localparam logic [OPC_FIELD_W-1:0] OPCODE_NOP = 4'h0;
    localparam logic [OPC_FIELD_W-1:0] OPCODE_ADD = 4'h1;
    localparam logic [OPC_FIELD_W-1:0] OPCODE_SUB = 4'h2;
    localparam logic [OPC_FIELD_W-1:0] OPCODE_AND = 4'h3;
    localparam logic [OPC_FIELD_W-1:0] OPCODE_OR  = 4'h4;
    localparam logic [OPC_FIELD_W-1:0] OPCODE_XOR = 4'h5;
    localparam logic [OPC_FIELD_W-1:0] OPCODE_LD  = 4'h6;
    localparam logic [OPC_FIELD_W-1:0] OPCODE_ST  = 4'h7;
    localparam logic [OPC_FIELD_W-1:0] OPCODE_LDI = 4'h8;
    localparam logic [OPC_FIELD_W-1:0] OPCODE_JMP = 4'h9;
    localparam logic [OPC_FIELD_W-1:0] OPCODE_BEQ = 4'hA;
    localparam logic [OPC_FIELD_W-1:0] OPCODE_HLT = 4'hF;

    localparam logic [REG_FIELD_W-1:0] R0 = 2'd0;
    localparam logic [REG_FIELD_W-1:0] R1 = 2'd1;
    localparam logic [REG_FIELD_W-1:0] R2 = 2'd2;
    localparam logic [REG_FIELD_W-1:0] R3 = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, registers each fetched word and
// presents it to decode over valid/ready, with stall, redirect, halt/restart.
module fetch_sequencer
    import uproc_pkg::*;
#(
    parameter int                ADDR_W   = PMEM_ADDR_W,
    parameter int                INS_W    = INS_WORD_W,
    parameter int                OPC_W    = OPC_FIELD_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic [ADDR_W-1:0] pp_addr_o,
    input  logic [INS_W-1:0]  pp_ins_i,
    output logic [INS_W-1:0]  ins_o,
    output logic [ADDR_W-1:0] ins_pc_o,
    output logic              ins_valid_o,
    input  logic              ins_ready_i,
    input  logic              redir_valid_i,
    input  logic [ADDR_W-1:0] redir_addr_i,
    output logic              halted_o,
    output logic [CNT_W-1:0]  fetch_cnt_o
);

    localparam logic [INS_W-1:0] NOP_WORD = {OPC_W'(OPCODE_NOP), {(INS_W-OPC_W){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INS_W-1:0]  ins_q, ins_d;
    logic [ADDR_W-1:0] ins_pc_q, ins_pc_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic advance;
    logic transfer;
    logic count_it;
    logic fetched_hlt;

    assign advance  = !valid_q || ins_ready_i;
    assign transfer = valid_q && ins_ready_i;
    // An X opcode compares as X, which the if() below treats as non-HLT.
    assign fetched_hlt = (pp_ins_i[INS_W-1 -: OPC_W] == OPC_W'(OPCODE_HLT));

    // Next-state, PC, output-register and counter logic.
    always_comb begin
        // NOTE: every target gets a hold default first so no path infers a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        ins_d    = ins_q;
        ins_pc_d = ins_pc_q;
        valid_d  = valid_q;
        count_it = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = FETCH;
            end
            FETCH: begin
                if (redir_valid_i) begin
                    // Flush: the word on the output is discarded, never counted.
                    pc_d    = redir_addr_i;
                    valid_d = 1'b0;
                end else if (advance) begin
                    ins_d    = pp_ins_i;
                    ins_pc_d = pc_q;
                    valid_d  = 1'b1;
                    count_it = transfer;
                    if (fetched_hlt) state_d = HALT;
                    else             pc_d    = pc_q + ADDR_W'(1);
                end
            end
            HALT: begin
                if (start_i) begin
                    // Restart drops any HLT word still waiting for decode.
                    pc_d    = RESET_PC;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (transfer) begin
                    valid_d  = 1'b0;
                    count_it = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        cnt_d = cnt_q;
        if (count_it && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            ins_q    <= NOP_WORD;
            ins_pc_q <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q  <= state_d;
            pc_q     <= pc_d;
            ins_q    <= ins_d;
            ins_pc_q <= ins_pc_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pp_addr_o   = pc_q;
    assign ins_o       = ins_q;
    assign ins_pc_o    = ins_pc_q;
    assign ins_valid_o = valid_q;
    assign halted_o    = (state_q == HALT);
    assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer. A second instance with a
// 4-bit counter runs alongside to show counter saturation.
module tb_fetch_sequencer;
    import uproc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i;
    logic [4:0] pp_addr, pp_addr4;
    logic [5:0] pp_ins, pp_ins4;
    logic [5:0] ins_o, ins_o4;
    logic [4:0] ins_pc, ins_pc4;
    logic       ins_valid, ins_valid4;
    logic       ins_ready;
    logic       redir_valid;
    logic [4:0] redir_addr;
    logic       halted, halted4;
    logic [7:0] cnt;
    logic [3:0] cnt4;

    logic [5:0] mem [32];

    int n_cmp = 0;
    int n_bad = 0;

    assign pp_ins  = mem[pp_addr];
    assign pp_ins4 = mem[pp_addr4];

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .pp_addr_o(pp_addr), .pp_ins_i(pp_ins),
        .ins_o(ins_o), .ins_pc_o(ins_pc), .ins_valid_o(ins_valid),
        .ins_ready_i(ins_ready), .redir_valid_i(redir_valid),
        .redir_addr_i(redir_addr), .halted_o(halted), .fetch_cnt_o(cnt)
    );

    fetch_sequencer #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .pp_addr_o(pp_addr4), .pp_ins_i(pp_ins4),
        .ins_o(ins_o4), .ins_pc_o(ins_pc4), .ins_valid_o(ins_valid4),
        .ins_ready_i(ins_ready), .redir_valid_i(redir_valid),
        .redir_addr_i(redir_addr), .halted_o(halted4), .fetch_cnt_o(cnt4)
    );

    // Opcodes 1..8 with the address's low bits in the register field: never HLT.
    task automatic load_default_mem();
        for (int i = 0; i < 32; i++) begin
            logic [4:0] a;
            a = 5'(i);
            mem[i] = {4'(1 + (i % 8)), a[1:0]};
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start_i = 1'b0; ins_ready = 1'b0;
        redir_valid = 1'b0; redir_addr = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Returns on the negedge after FETCH is entered (valid still 0).
    task automatic pulse_start();
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
    endtask

    task automatic test_reset();
        load_default_mem();
        do_reset();
        n_cmp++; if (ins_o !== 6'b000000) begin n_bad++; $display("FAIL reset_ins actual=%b required=000000", ins_o); end
        n_cmp++; if (ins_pc !== 5'd0) begin n_bad++; $display("FAIL reset_ins_pc actual=%0d required=0", ins_pc); end
        n_cmp++; if (ins_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid actual=%b required=0", ins_valid); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted actual=%b required=0", halted); end
        n_cmp++; if (cnt !== 8'd0) begin n_bad++; $display("FAIL reset_cnt actual=%0d required=0", cnt); end
        n_cmp++; if (pp_addr !== 5'd0) begin n_bad++; $display("FAIL reset_pc actual=%0d required=0", pp_addr); end
        // IDLE without start: nothing moves even with ready high.
        ins_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (ins_valid !== 1'b0 || pp_addr !== 5'd0) begin
            n_bad++; $display("FAIL idle_static valid=%b pc=%0d required valid=0 pc=0", ins_valid, pp_addr);
        end
    endtask

    task automatic test_stream();
        do_reset();
        ins_ready = 1'b1;
        pulse_start();
        n_cmp++; if (ins_valid !== 1'b0 || pp_addr !== 5'd0) begin
            n_bad++; $display("FAIL start_latency valid=%b pc=%0d required valid=0 pc=0", ins_valid, pp_addr);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++; if (ins_valid !== 1'b1 || ins_pc !== 5'(k) || ins_o !== mem[k]) begin
                n_bad++; $display("FAIL stream_%0d valid=%b pc=%0d ins=%b required valid=1 pc=%0d ins=%b",
                                  k, ins_valid, ins_pc, ins_o, k, mem[k]);
            end
        end
        @(negedge clk);
        n_cmp++; if (cnt !== 8'd5) begin n_bad++; $display("FAIL stream_cnt actual=%0d required=5", cnt); end
    endtask

    task automatic test_stall();
        do_reset();
        ins_ready = 1'b1;
        pulse_start();
        repeat (2) @(negedge clk);   // word 1 shown, pc = 2
        ins_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if (ins_valid !== 1'b1 || ins_pc !== 5'd1 || ins_o !== mem[1] || pp_addr !== 5'd2 || cnt !== 8'd1) begin
                n_bad++; $display("FAIL stall_%0d valid=%b ins_pc=%0d ins=%b pc=%0d cnt=%0d required 1/1/%b/2/1",
                                  k, ins_valid, ins_pc, ins_o, pp_addr, cnt, mem[1]);
            end
        end
        ins_ready = 1'b1;
        for (int k = 2; k < 4; k++) begin
            @(negedge clk);
            n_cmp++; if (ins_valid !== 1'b1 || ins_pc !== 5'(k) || ins_o !== mem[k] || cnt !== 8'(k)) begin
                n_bad++; $display("FAIL resume_%0d valid=%b ins_pc=%0d cnt=%0d required valid=1 ins_pc=%0d cnt=%0d",
                                  k, ins_valid, ins_pc, cnt, k, k);
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        ins_ready = 1'b1;
        pulse_start();
        repeat (5) @(negedge clk);   // word 4 shown, pc = 5
        redir_valid = 1'b1; redir_addr = 5'd20;
        @(negedge clk);
        redir_valid = 1'b0; redir_addr = 5'd0;
        n_cmp++; if (ins_valid !== 1'b0 || pp_addr !== 5'd20 || cnt !== 8'd4) begin
            n_bad++; $display("FAIL redir_flush valid=%b pc=%0d cnt=%0d required valid=0 pc=20 cnt=4", ins_valid, pp_addr, cnt);
        end
        @(negedge clk);
        n_cmp++; if (ins_valid !== 1'b1 || ins_pc !== 5'd20 || ins_o !== mem[20] || cnt !== 8'd4) begin
            n_bad++; $display("FAIL redir_target valid=%b ins_pc=%0d ins=%b cnt=%0d required 1/20/%b/4",
                              ins_valid, ins_pc, ins_o, cnt, mem[20]);
        end
        @(negedge clk);
        n_cmp++; if (ins_pc !== 5'd21 || cnt !== 8'd5) begin
            n_bad++; $display("FAIL redir_next ins_pc=%0d cnt=%0d required ins_pc=21 cnt=5", ins_pc, cnt);
        end
    endtask

    task automatic test_halt();
        do_reset();
        mem[7] = {OPCODE_HLT, R1};
        ins_ready = 1'b1;
        pulse_start();
        repeat (8) @(negedge clk);   // HLT word at 7 shown
        n_cmp++; if (ins_valid !== 1'b1 || ins_pc !== 5'd7 || ins_o !== {OPCODE_HLT, R1} || halted !== 1'b1 || pp_addr !== 5'd7) begin
            n_bad++; $display("FAIL halt_word valid=%b ins_pc=%0d ins=%b halted=%b pc=%0d required 1/7/111101/1/7",
                              ins_valid, ins_pc, ins_o, halted, pp_addr);
        end
        redir_valid = 1'b1; redir_addr = 5'd3;
        @(negedge clk);
        redir_valid = 1'b0;
        n_cmp++; if (ins_valid !== 1'b0 || halted !== 1'b1 || pp_addr !== 5'd7 || cnt !== 8'd8) begin
            n_bad++; $display("FAIL halt_accepted valid=%b halted=%b pc=%0d cnt=%0d required 0/1/7/8", ins_valid, halted, pp_addr, cnt);
        end
        @(negedge clk);
        n_cmp++; if (ins_valid !== 1'b0 || pp_addr !== 5'd7) begin
            n_bad++; $display("FAIL halt_hold valid=%b pc=%0d required valid=0 pc=7", ins_valid, pp_addr);
        end
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n_cmp++; if (halted !== 1'b0 || ins_valid !== 1'b0 || pp_addr !== 5'd0) begin
            n_bad++; $display("FAIL restart halted=%b valid=%b pc=%0d required 0/0/0", halted, ins_valid, pp_addr);
        end
        @(negedge clk);
        n_cmp++; if (ins_valid !== 1'b1 || ins_pc !== 5'd0) begin
            n_bad++; $display("FAIL restart_first valid=%b ins_pc=%0d required valid=1 ins_pc=0", ins_valid, ins_pc);
        end
        load_default_mem();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 32; i++) begin
            logic [4:0] a;
            a = 5'(i);
            mem[i] = {OPCODE_NOP, a[1:0]};
        end
        do_reset();
        ins_ready = 1'b1;
        pulse_start();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n_cmp++; if (ins_valid !== 1'b1 || ins_pc !== 5'(k % 32) || cnt !== 8'(k)) begin
                n_bad++; $display("FAIL wrap_%0d valid=%b ins_pc=%0d cnt=%0d required valid=1 ins_pc=%0d cnt=%0d",
                                  k, ins_valid, ins_pc, cnt, k % 32, k);
            end
            n_cmp++; if (cnt4 !== 4'((k > 15) ? 15 : k)) begin
                n_bad++; $display("FAIL sat_%0d cnt4=%0d required %0d", k, cnt4, (k > 15) ? 15 : k);
            end
        end
        load_default_mem();
    endtask

    task automatic test_async_reset();
        do_reset();
        ins_ready = 1'b1;
        pulse_start();
        repeat (9) @(negedge clk);   // word 8 shown, pc = 9
        ins_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (ins_valid !== 1'b1 || ins_pc !== 5'd8 || pp_addr !== 5'd9) begin
            n_bad++; $display("FAIL pre_reset_stall valid=%b ins_pc=%0d pc=%0d required 1/8/9", ins_valid, ins_pc, pp_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (ins_valid !== 1'b0 || ins_pc !== 5'd0 || pp_addr !== 5'd0 || ins_o !== 6'b000000 || cnt !== 8'd0 || halted !== 1'b0) begin
            n_bad++; $display("FAIL async_reset valid=%b ins_pc=%0d pc=%0d ins=%b cnt=%0d halted=%b required all zero",
                              ins_valid, ins_pc, pp_addr, ins_o, cnt, halted);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
